// File: rtl/d_latch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d_latch_pkg
// Description : Shared constants and stimulus type for the clock-sampled
//               D-latch storage cell.
// Revision    : 1.0 - initial release
// ============================================================================
package d_latch_pkg;

    // Value loaded into every stored bit on reset
    localparam logic D_LATCH_RESET_Q     = 1'b0;

    // Depth of the optional input synchronizer
    localparam int   D_LATCH_SYNC_STAGES = 2;

    // One {enable, d} stimulus pair for a one-bit cell
    typedef struct packed {
        logic enable;
        logic d;
    } d_latch_stim_t;

endpackage : d_latch_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Multi-bit flop-chain synchronizer (two stages by default)
//               with synchronous active-high reset. Each bit is synchronized
//               independently; no cross-bit coherency is implied.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import d_latch_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = D_LATCH_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    // Shift the input through the flop chain; reset clears every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : sync_2ff
`default_nettype wire

// File: rtl/d_latch_core.sv
`default_nettype none
// ============================================================================
// Module      : d_latch_core
// Description : Clock-sampled D-latch. While the effective enable is high the
//               stored value follows the effective data; while low it holds.
//               q is registered, q_n is its combinational complement.
//               Optional macro D_LATCH_INPUT_SYNC_EN inserts a two-flop
//               synchronizer on d and enable (latency 3 instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
module d_latch_core
    import d_latch_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] w_d_eff;
    logic             w_en_eff;
    logic [WIDTH-1:0] r_q;

`ifdef D_LATCH_INPUT_SYNC_EN
    // enable and d share one synchronizer so they age by the same number of
    // stages; reset still acts on the storage register directly.
    logic [WIDTH:0] w_sync_out;

    sync_2ff #(
        .WIDTH  (WIDTH + 1),
        .STAGES (D_LATCH_SYNC_STAGES)
    ) u_sync (
        .clk (clock),
        .rst (reset),
        .i_d ({enable, d}),
        .o_q (w_sync_out)
    );

    assign w_en_eff = w_sync_out[WIDTH];
    assign w_d_eff  = w_sync_out[WIDTH-1:0];
`else
    assign w_en_eff = enable;
    assign w_d_eff  = d;
`endif

    // Storage register: reset beats enable, enable loads, otherwise hold
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= {WIDTH{D_LATCH_RESET_Q}};
        end else if (w_en_eff) begin
            r_q <= w_d_eff;
        end
    end

    assign q   = r_q;
    assign q_n = ~r_q;

endmodule : d_latch_core
`default_nettype wire

// File: tb/tb_d_latch_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_latch_core
// Description : Self-checking bench for d_latch_core (WIDTH=1 and WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_latch_core;
    import d_latch_pkg::*;

`ifdef D_LATCH_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        d_latch_stim_t stim;
        logic          exp_q;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       d;
    logic       q;
    logic       q_n;

    logic       reset4;
    logic       enable4;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [3:0] qn4;

    int         errors = 0;
    int         checks = 0;
    vec_t       tab[$];

    always #5 clock = ~clock;

    d_latch_core #(.WIDTH(1)) u_dut1 (
        .clock  (clock),
        .reset  (reset),
        .d      (d),
        .enable (enable),
        .q      (q),
        .q_n    (q_n)
    );

    d_latch_core #(.WIDTH(4)) u_dut4 (
        .clock  (clock),
        .reset  (reset4),
        .d      (d4),
        .enable (enable4),
        .q      (q4),
        .q_n    (qn4)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic en, input logic dv, input logic eq, input int n);
        vec_t v;
        v.stim.enable = en;
        v.stim.d      = dv;
        v.exp_q       = eq;
        for (int k = 0; k < n; k++) tab.push_back(v);
    endtask

    initial begin
        int idx;
        int j;

        reset   = 1'b1; enable  = 1'b1; d  = 1'b1;
        reset4  = 1'b1; enable4 = 1'b0; d4 = 4'h0;

        // Reset with enable=1, d=1 for two cycles
        for (int k = 0; k < 2; k++) begin
            tick;
            check("reset_q",   {3'b0, q},   4'h0);
            check("reset_q_n", {3'b0, q_n}, 4'h1);
        end
        check("reset_q4",  q4,  4'h0);
        check("reset_qn4", qn4, 4'hF);

        reset  = 1'b0;
        reset4 = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            tick;
            check("release_wait_q", {3'b0, q}, 4'h0);
        end
        tick;
        check("release_q",   {3'b0, q},   4'h1);
        check("release_q_n", {3'b0, q_n}, 4'h0);

        // Vectors: each expectation is q once that vector has propagated
        add(1'b1, 1'b0, 1'b0, 3);   // load zero
        add(1'b0, 1'b0, 1'b0, 10);  // hold low, {en,d}=00
        add(1'b0, 1'b1, 1'b0, 10);  // hold low, {en,d}=01
        add(1'b1, 1'b1, 1'b1, 3);   // load one
        add(1'b1, 1'b0, 1'b1, 0);
        add(1'b0, 1'b0, 1'b1, 3);   // hold high, 00
        add(1'b0, 1'b1, 1'b1, 3);   // hold high, 01
        add(1'b1, 1'b0, 1'b0, 2);   // load zero over one
        add(1'b0, 1'b1, 1'b0, 3);   // stays zero during 01
        add(1'b1, 1'b1, 1'b1, 1);   // transparency: d toggles
        add(1'b1, 1'b0, 1'b0, 1);
        add(1'b1, 1'b1, 1'b1, 1);
        add(1'b1, 1'b0, 1'b0, 1);
        add(1'b1, 1'b1, 1'b1, 1);
        add(1'b1, 1'b0, 1'b0, 1);
        add(1'b1, 1'b1, 1'b1, 1);
        add(1'b1, 1'b0, 1'b0, 1);
        add(1'b0, 1'b1, 1'b0, 2);   // enable falls as d rises: keep 0
        add(1'b1, 1'b1, 1'b1, 1);
        add(1'b0, 1'b0, 1'b1, 2);   // enable falls as d falls: keep 1

        for (int i = 0; i < tab.size() + LAT - 1; i++) begin
            idx    = (i < tab.size()) ? i : tab.size() - 1;
            enable = tab[idx].stim.enable;
            d      = tab[idx].stim.d;
            tick;
            if (i >= LAT - 1) begin
                j = i - (LAT - 1);
                check($sformatf("vec%0d_q", j),   {3'b0, q},   {3'b0, tab[j].exp_q});
                check($sformatf("vec%0d_q_n", j), {3'b0, q_n}, {3'b0, ~tab[j].exp_q});
            end
        end

        // WIDTH=4: load 4'hA, hold, reset mid-hold, hold zero, reload
        enable4 = 1'b1; d4 = 4'hA;
        repeat (LAT) tick;
        check("w4_load_q",  q4,  4'hA);
        check("w4_load_qn", qn4, 4'h5);
        enable4 = 1'b0; d4 = 4'h3;
        for (int k = 0; k < LAT + 1; k++) begin
            tick;
            check("w4_hold_q",  q4,  4'hA);
            check("w4_hold_qn", qn4, 4'h5);
        end
        reset4 = 1'b1;
        tick;
        check("w4_rst_q",  q4,  4'h0);
        check("w4_rst_qn", qn4, 4'hF);
        reset4 = 1'b0; d4 = 4'hF;
        for (int k = 0; k < LAT + 2; k++) begin
            tick;
            check("w4_post_rst_q", q4, 4'h0);
        end
        enable4 = 1'b1;
        for (int k = 0; k < LAT - 1; k++) begin
            tick;
            check("w4_reload_wait_q", q4, 4'h0);
        end
        tick;
        check("w4_reload_q",  q4,  4'hF);
        check("w4_reload_qn", qn4, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_d_latch_core
`default_nettype wire
